// File: rtl/xil_cdc_pkg.sv
// Shared constants and elaboration-time helpers for the Xilinx-style CDC primitives.
package xil_cdc_pkg;

    localparam int CDC_SYNC_MIN = 2;
    localparam int CDC_SYNC_MAX = 10;

    function automatic bit cdc_sync_ok(input int stages);
        return (stages >= CDC_SYNC_MIN) && (stages <= CDC_SYNC_MAX);
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-stage single-bit synchronizer with asynchronous active-high clear.
module cdc_sync_bit
    import xil_cdc_pkg::*;
#(
    parameter int STAGES = 4
) (
    input  logic _w_CLR,
    input  logic clk,
    input  logic d,
    output logic q
);

    if (!cdc_sync_ok(STAGES)) begin : g_bad_stages
        $error("cdc_sync_bit: STAGES=%0d outside %0d..%0d", STAGES, CDC_SYNC_MIN, CDC_SYNC_MAX);
    end

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync;

    always_ff @(posedge clk or posedge _w_CLR) begin
        if (_w_CLR) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/cdc_pulse_hs.sv
// Single-bit pulse CDC with toggle handshake; reports busy and refused requests.
module cdc_pulse_hs
    import xil_cdc_pkg::*;
#(
    parameter int DEST_SYNC_FF = 4,
    parameter int SRC_SYNC_FF  = 4
) (
    input  logic _w_CLR,
    input  logic src_clk,
    input  logic dest_clk,
    input  logic src_pulse,
    output logic src_busy,
    output logic src_drop,
    output logic dest_pulse
);

    if (!cdc_sync_ok(DEST_SYNC_FF) || !cdc_sync_ok(SRC_SYNC_FF)) begin : g_bad_params
        $error("cdc_pulse_hs: DEST_SYNC_FF=%0d SRC_SYNC_FF=%0d outside %0d..%0d",
               DEST_SYNC_FF, SRC_SYNC_FF, CDC_SYNC_MIN, CDC_SYNC_MAX);
    end

    logic src_tgl;
    logic ack_q;
    logic dst_q;
    logic dst_tgl;

    cdc_sync_bit #(.STAGES(DEST_SYNC_FF)) u_dest_sync (
        ._w_CLR (_w_CLR),
        .clk    (dest_clk),
        .d      (src_tgl),
        .q      (dst_q)
    );

    // Ack returns dst_tgl, not dst_q, so busy clears only once the pulse was emitted.
    cdc_sync_bit #(.STAGES(SRC_SYNC_FF)) u_ack_sync (
        ._w_CLR (_w_CLR),
        .clk    (src_clk),
        .d      (dst_tgl),
        .q      (ack_q)
    );

    assign src_busy = src_tgl ^ ack_q;

    always_ff @(posedge src_clk or posedge _w_CLR) begin
        if (_w_CLR) begin
            src_tgl  <= 1'b0;
            src_drop <= 1'b0;
        end else begin
            src_drop <= src_pulse & src_busy;
            if (src_pulse && !src_busy) begin
                src_tgl <= ~src_tgl;
            end
        end
    end

    always_ff @(posedge dest_clk or posedge _w_CLR) begin
        if (_w_CLR) begin
            dst_tgl    <= 1'b0;
            dest_pulse <= 1'b0;
        end else begin
            dst_tgl    <= dst_q;
            dest_pulse <= dst_q ^ dst_tgl;
        end
    end

endmodule

// File: tb/tb_cdc_pulse_hs.sv
// Bench for cdc_pulse_hs: equal-clock timing against an event-level model, reset abort, and a 100/~23 MHz random run.
`timescale 1ns/1ps
module tb_cdc_pulse_hs;

    localparam int LMAX = 100;

    logic _w_CLR;
    logic src_clk;
    logic dest_clk;
    logic sp [2];
    logic bz [2];
    logic dr [2];
    logic dp [2];

    int total = 0;
    int bad   = 0;

    bit eq = 1'b1;
    int t  = 0;

    bit stim [LMAX];
    bit e_dp [2][LMAX];
    bit e_bz [2][LMAX];
    bit e_dr [2][LMAX];

    bit mon_en = 1'b0;
    int n_pulse [2];
    int n_drop  [2];
    bit prev_dp [2];

    cdc_pulse_hs #(.DEST_SYNC_FF(4), .SRC_SYNC_FF(4)) u_dut0 (
        ._w_CLR     (_w_CLR),
        .src_clk    (src_clk),
        .dest_clk   (dest_clk),
        .src_pulse  (sp[0]),
        .src_busy   (bz[0]),
        .src_drop   (dr[0]),
        .dest_pulse (dp[0])
    );

    cdc_pulse_hs #(.DEST_SYNC_FF(2), .SRC_SYNC_FF(10)) u_dut1 (
        ._w_CLR     (_w_CLR),
        .src_clk    (src_clk),
        .dest_clk   (dest_clk),
        .src_pulse  (sp[1]),
        .src_busy   (bz[1]),
        .src_drop   (dr[1]),
        .dest_pulse (dp[1])
    );

    // Both clocks from one process so equal-clock edges land in the same step.
    initial begin
        src_clk  = 1'b0;
        dest_clk = 1'b0;
        forever begin
            #1;
            t++;
            if (t % 5 == 0) src_clk = ~src_clk;
            if (eq) dest_clk = src_clk;
            else if (t % 22 == 0) dest_clk = ~dest_clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int nff(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int mff(input int d);
        return (d == 0) ? 4 : 10;
    endfunction

    // Event-level model: an accept at edge e owns the channel for N+M+2 edges,
    // pulses after edge e+N+1, and shows busy after edges e..e+N+M.
    task automatic model(input int d, input int len);
        int n;
        int per;
        int next_free;
        n = nff(d);
        per = nff(d) + mff(d) + 2;
        next_free = 0;
        for (int k = 0; k < LMAX; k++) begin
            e_dp[d][k] = 1'b0;
            e_bz[d][k] = 1'b0;
            e_dr[d][k] = 1'b0;
        end
        for (int e = 0; e < len; e++) begin
            if (stim[e]) begin
                if (e >= next_free) begin
                    if (e + n + 1 < LMAX) e_dp[d][e + n + 1] = 1'b1;
                    for (int j = e; j <= e + per - 2 && j < LMAX; j++) e_bz[d][j] = 1'b1;
                    next_free = e + per;
                end else begin
                    e_dr[d][e] = 1'b1;
                end
            end
        end
    endtask

    task automatic run_seq(input string name, input int len);
        model(0, len);
        model(1, len);
        for (int k = 0; k < len; k++) begin
            sp[0] = stim[k];
            sp[1] = stim[k];
            @(posedge src_clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s.d%0d.dest_pulse@%0d", name, d, k), {31'd0, dp[d]}, {31'd0, e_dp[d][k]});
                chk($sformatf("%s.d%0d.src_busy@%0d", name, d, k), {31'd0, bz[d]}, {31'd0, e_bz[d][k]});
                chk($sformatf("%s.d%0d.src_drop@%0d", name, d, k), {31'd0, dr[d]}, {31'd0, e_dr[d][k]});
            end
        end
        sp[0] = 1'b0;
        sp[1] = 1'b0;
    endtask

    always @(negedge src_clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) if (dr[d]) n_drop[d]++;
        end
    end

    always @(negedge dest_clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (prev_dp[d]) chk($sformatf("ratio.d%0d.pulse_width", d), {31'd0, dp[d]}, 32'd0);
                if (dp[d]) n_pulse[d]++;
                prev_dp[d] = dp[d];
            end
        end
    end

    initial begin
        _w_CLR = 1'b1;
        sp[0] = 1'b0;
        sp[1] = 1'b0;
        n_pulse = '{0, 0};
        n_drop  = '{0, 0};
        prev_dp = '{1'b0, 1'b0};
        repeat (14) @(posedge src_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset.d%0d.busy", d), {31'd0, bz[d]}, 32'd0);
            chk($sformatf("reset.d%0d.drop", d), {31'd0, dr[d]}, 32'd0);
            chk($sformatf("reset.d%0d.dest_pulse", d), {31'd0, dp[d]}, 32'd0);
        end
        _w_CLR = 1'b0;
        repeat (2) @(posedge src_clk);
        #1;

        // single request at 0, then one right as the default config frees up
        for (int k = 0; k < LMAX; k++) stim[k] = 1'b0;
        stim[0] = 1'b1;
        stim[10] = 1'b1;
        run_seq("single", 40);

        for (int k = 0; k < LMAX; k++) stim[k] = (k < 12);
        run_seq("held", 40);

        for (int k = 0; k < LMAX; k++) stim[k] = (k < 44) && ($urandom_range(0, 2) == 0);
        run_seq("rand_eq", 64);

        // reset mid-flight: 3 cycles after an accept
        sp[0] = 1'b1;
        sp[1] = 1'b1;
        @(posedge src_clk);
        #1;
        sp[0] = 1'b0;
        sp[1] = 1'b0;
        repeat (3) @(posedge src_clk);
        #1;
        _w_CLR = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abort.d%0d.busy", d), {31'd0, bz[d]}, 32'd0);
            chk($sformatf("abort.d%0d.drop", d), {31'd0, dr[d]}, 32'd0);
            chk($sformatf("abort.d%0d.dest_pulse", d), {31'd0, dp[d]}, 32'd0);
        end
        repeat (12) @(posedge src_clk);
        #1;
        _w_CLR = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge src_clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("post_abort.d%0d.dest_pulse@%0d", d, k), {31'd0, dp[d]}, 32'd0);
                chk($sformatf("post_abort.d%0d.busy@%0d", d, k), {31'd0, bz[d]}, 32'd0);
            end
        end

        // 100 MHz src vs ~22.7 MHz dest, 200 single-cycle random requests
        eq = 1'b0;
        repeat (4) @(posedge dest_clk);
        @(posedge src_clk);
        #1;
        mon_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 12)) @(posedge src_clk);
            #1;
            sp[0] = 1'b1;
            sp[1] = 1'b1;
            @(posedge src_clk);
            #1;
            sp[0] = 1'b0;
            sp[1] = 1'b0;
        end
        for (int c = 0; c < 400 && (bz[0] || bz[1]); c++) @(posedge src_clk);
        #1;
        chk("ratio.d0.drained", {31'd0, bz[0]}, 32'd0);
        chk("ratio.d1.drained", {31'd0, bz[1]}, 32'd0);
        repeat (4) @(posedge dest_clk);
        @(negedge dest_clk);
        #1;
        mon_en = 1'b0;
        chk("ratio.d0.conserve", n_pulse[0] + n_drop[0], 32'd200);
        chk("ratio.d1.conserve", n_pulse[1] + n_drop[1], 32'd200);
        chk("ratio.d0.some_delivered", {31'd0, n_pulse[0] > 0}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
